ascon_blk_seq: RTL

Input block sequencer for the ASCON-128 core. It accepts associated-data (AD) and plaintext as a stream of 32-bit words and assembles them into 64-bit rate blocks. It applies ASCON 10* padding and hands each block to the permutation datapath through a valid/ready handshake, marking phase and last-block status. It sits between the bus-side word FIFO and the ASCON state/permutation core, and is the only block that decides block count and padding.

---
 rtl/ascon_blk_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ascon_blk_seq.sv
// ascon_blk_seq: packs 32-bit AD/plaintext words into 10*-padded 64-bit ASCON rate blocks.
// Define ASCON_SEQ_DSEP_EN to pulse dsep_o during the SEP cycle; otherwise dsep_o is tied low.
module ascon_blk_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  ad_size_i,
  input  logic [6:0]  text_size_i,
  input  logic [31:0] word_i,
  input  logic        word_vld_i,
  output logic        word_rdy_o,
  output logic [63:0] blk_o,
  output logic        blk_vld_o,
  input  logic        blk_rdy_i,
  output logic        blk_text_o,
  output logic        blk_last_o,
  output logic        dsep_o,
  output logic        busy_o,
  output logic        done_o
);
`ifdef ASCON_SEQ_DSEP_EN
  localparam logic DSEP = 1'b1;
`else
  localparam logic DSEP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, AD, SEP, TXT, DONE} state_t;
  state_t      state;
  logic [6:0]  txt_size_r, words_left;
  logic [2:0]  rem_r;
  logic [4:0]  blks_left;
  logic [31:0] hi_r;
  logic        have_hi, take, pad_only, form, fin, acc, in_phase;
  logic [63:0] raw, padded;
  function automatic logic [6:0] nwords(input logic [6:0] s);
    logic [7:0] t;
    t = {1'b0, s} + 8'd3;
    return {1'b0, t[7:2]};
  endfunction
  function automatic logic [4:0] nblks(input logic [6:0] s);
    return {1'b0, s[6:3]} + 5'd1;
  endfunction
  assign in_phase   = state == AD || state == TXT;
  assign word_rdy_o = in_phase && words_left != 7'd0 && !blk_vld_o;
  assign take       = word_vld_i && word_rdy_o;
  assign acc        = blk_vld_o && blk_rdy_i;
  // A block with no words is only ever the trailing full-padding block (size a multiple of 8).
  assign pad_only   = in_phase && words_left == 7'd0 && !have_hi && !blk_vld_o && blks_left != 5'd0;
  assign form       = (take && (have_hi || words_left == 7'd1)) || pad_only;
  assign fin        = blks_left == 5'd1;
  assign raw        = pad_only ? 64'd0 : have_hi ? {hi_r, word_i} : {word_i, 32'd0};
  always_comb begin
    padded = raw;
    for (int i = 0; i < 8; i++)
      if (fin) padded[63-8*i -: 8] = i < int'(rem_r) ? raw[63-8*i -: 8] : i == int'(rem_r) ? 8'h80 : 8'h00;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      txt_size_r <= '0;
      words_left <= '0;
      rem_r      <= '0;
      blks_left  <= '0;
      hi_r       <= '0;
      have_hi    <= 1'b0;
      blk_o      <= '0;
      blk_vld_o  <= 1'b0;
      blk_text_o <= 1'b0;
      blk_last_o <= 1'b0;
      dsep_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      dsep_o <= 1'b0;
      if (acc) blk_vld_o <= 1'b0;
      if (take) words_left <= words_left - 7'd1;
      if (take && !form) begin
        hi_r    <= word_i;
        have_hi <= 1'b1;
      end
      if (form) begin
        blk_o      <= padded;
        blk_vld_o  <= 1'b1;
        blk_last_o <= fin;
        blk_text_o <= state == TXT;
        blks_left  <= blks_left - 5'd1;
        have_hi    <= 1'b0;
      end
      case (state)
        IDLE: if (start_i) begin
          txt_size_r <= text_size_i;
          rem_r      <= ad_size_i[2:0];
          words_left <= nwords(ad_size_i);
          blks_left  <= ad_size_i == 7'd0 ? 5'd0 : nblks(ad_size_i);
          busy_o     <= 1'b1;
          dsep_o     <= DSEP && ad_size_i == 7'd0;
          state      <= ad_size_i != 7'd0 ? AD : SEP;
        end
        AD: if (acc && blk_last_o) begin
          dsep_o <= DSEP;
          state  <= SEP;
        end
        SEP: begin
          rem_r      <= txt_size_r[2:0];
          words_left <= nwords(txt_size_r);
          blks_left  <= nblks(txt_size_r);
          state      <= TXT;
        end
        TXT: if (acc && blk_last_o) begin
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
